mul_pipe_gen: RTL and testbench
===============================

// Module: mul_pipe_gen
// PURPOSE
//  Parametrised pipelined integer multiplier for the PU fixed-point unit; successor of the fixed-latency mul pipe.
//  Full DWIDTHxDWIDTH product (hi/lo words), signed/unsigned per operation, and CR fields for both words.
//  Configurable latency, valid/ready backpressure, tag pass-through and pipeline flush.
//  Sits between issue and writeback; the tag identifies the destination/ROB slot.
// PARAMETERS
//  DWIDTH     32  operand width; the product is 2*DWIDTH
//  STAGES     3   accept-to-out_valid latency in cycles when not stalled; legal range 1..8
//  TAG_WIDTH  5   width of the opaque tag carried alongside each operation
// PORTS
//  clk        in   1          clock; all state updates on its rising edge
//  reset_n    in   1          asynchronous, active-low reset
//  flush      in   1          drop every in-flight operation
//  in_valid   in   1          operation offered
//  in_ready   out  1          operation accepted when in_valid && in_ready
//  uns        in   1          1 = unsigned, 0 = two's-complement signed
//  a, b       in   DWIDTH     operands
//  in_tag     in   TAG_WIDTH  tag, returned unchanged
//  out_valid  out  1          result present
//  out_ready  in   1          consumer takes the result when out_valid && out_ready
//  res_hi     out  DWIDTH     product[2*DWIDTH-1:DWIDTH]
//  res_lo     out  DWIDTH     product[DWIDTH-1:0]
//  crf_hi     out  Cr_field   compare bits of res_hi
//  crf_lo     out  Cr_field   compare bits of res_lo, including ov
//  out_tag    out  TAG_WIDTH  tag of the result
// BEHAVIOUR
//  - Reset (reset_n=0, takes effect immediately): all valid bits, res_*, crf_*, out_tag = 0; out_valid=0.
//    * in_ready comes out of reset at 1.
//  - Arithmetic: extend both operands to DWIDTH+1 bits, then do a signed multiply.
//    * The extension bit is ~uns & msb.
//    * product = low 2*DWIDTH bits of the result.
//  - Pipeline: STAGES register stages, each holding {valid, uns, product, tag}.
//    * The multiply may be retimed across stages.
//    * CR fields are computed from the last-stage product and registered together with out_valid.
//  - stall = out_valid && !out_ready. While stalled, every stage holds and in_ready = 0.
//    * Bubbles are not compressed.
//    * in_ready = !stall && !flush. It is combinational from out_ready and flush.
//  - Latency: an op accepted in cycle t gives out_valid in cycle t+STAGES if no stall occurs.
//    * Throughput is 1 op/cycle.
//    * Results leave in acceptance order.
//  - Output hold: while out_valid && !out_ready, res_*, crf_*, out_tag stay stable.
//  - flush: in the next cycle, every valid bit and out_valid = 0.
//    * Flush overrides stall and any accept in the same cycle; an op offered that cycle is not accepted.
//    * Data registers may keep stale values.
//  - CR fields (lt/gt/eq use signed interpretation of the word, regardless of uns):
//    * lt = msb set.
//    * eq = word == 0.
//    * gt = otherwise.
//    * Exactly one of lt/gt/eq is set. crf_hi.ov = 0.
//    * crf_lo.ov, signed: 1 if res_hi != {DWIDTH{res_lo[DWIDTH-1]}}.
//    * crf_lo.ov, unsigned: 1 if res_hi != 0.
//  - STAGES=1: product and CR fields are registered once; out_valid appears the cycle after accept.
// STRUCTURE
//  - Pu_types package: DWIDTH, Cr_field, plus a new function cr_from_word(word) -> Cr_field (lt/gt/eq only).
//  - Sub-module mul_crf_gen (combinational).
//    * Inputs: res_hi, res_lo, uns. Outputs: crf_hi, crf_lo.
//    * Reused by the divider.
//  - Pipeline implemented as a generate loop over STAGES using a packed stage struct local to this module.
// TESTING (DWIDTH=32, STAGES=3)
//  - signed a=0xFFFFFFFD (-3), b=5 accepted at t:
//    * out_valid at t+3; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//    * crf_lo.lt=1, ov=0; crf_hi.lt=1.
//  - a=b=0xFFFFFFFF:
//    * uns=1: hi=0xFFFFFFFE, lo=0x00000001, crf_lo.gt=1, ov=1.
//    * uns=0: hi=0, lo=1, crf_hi.eq=1, crf_lo.ov=0.
//  - signed 0x80000000*0x80000000: hi=0x40000000, lo=0, crf_lo.eq=1, ov=1, crf_hi.gt=1.
//  - Stream of 6 ops, tags 0..5; out_ready held low for 4 cycles after the first result:
//    * in_ready=0 while stalled; no op lost or duplicated.
//    * Tags emerge in order 0..5 with correct products.
//  - flush one cycle after accepting tags 1,2 (offer tag 3 in the flush cycle):
//    * No out_valid for tags 1..3; the op accepted next returns after exactly 3 cycles.
//  - reset_n pulled low with 2 ops in flight and out_valid=1:
//    * Outputs go to 0 asynchronously; after release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/mul_pipe_gen_pkg.sv
// Shared fixed-point unit types: operand width, compare-field layout and the
// lt/gt/eq classifier used by the multiplier and divider result paths.
package Pu_types;

    localparam int DWIDTH = 32;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic ov;
    } Cr_field;

    // Signed classification of a word; ov is left clear for the caller to fill.
    function automatic Cr_field cr_from_word(input logic [DWIDTH-1:0] word);
        Cr_field cr;
        cr.lt = word[DWIDTH-1];
        cr.eq = (word == '0);
        cr.gt = !cr.lt && !cr.eq;
        cr.ov = 1'b0;
        return cr;
    endfunction

endpackage

// File: rtl/mul_crf_gen.sv
// Combinational compare fields for a double-word result (hi/lo);
// crf_lo.ov flags a product that does not fit in the low word.
module mul_crf_gen
    import Pu_types::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] res_hi,
    input  logic [DWIDTH-1:0] res_lo,
    input  logic              uns,
    output Cr_field           crf_hi,
    output Cr_field           crf_lo
);

    always_comb begin
        crf_hi    = cr_from_word(res_hi);
        crf_lo    = cr_from_word(res_lo);
        crf_lo.ov = uns ? (res_hi != '0)
                        : (res_hi != {DWIDTH{res_lo[DWIDTH-1]}});
    end

endmodule

// File: rtl/mul_pipe_gen.sv
// Pipelined DWIDTHxDWIDTH signed/unsigned multiplier with tag pass-through,
// whole-pipe stall on output backpressure and single-cycle flush.
module mul_pipe_gen
    import Pu_types::*;
#(
    parameter int DWIDTH    = 32,
    parameter int STAGES    = 3,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 uns,
    input  logic [DWIDTH-1:0]    a,
    input  logic [DWIDTH-1:0]    b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DWIDTH-1:0]    res_hi,
    output logic [DWIDTH-1:0]    res_lo,
    output Cr_field              crf_hi,
    output Cr_field              crf_lo,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int PW = 2 * DWIDTH;

    typedef struct packed {
        logic                 valid;
        logic                 uns;
        logic [PW-1:0]        product;
        logic [TAG_WIDTH-1:0] tag;
    } stage_t;

    logic                 stall;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] full_prod;
    stage_t               in_stage;
    stage_t               last_feed;
    Cr_field              crf_hi_next, crf_lo_next;
    Cr_field              crf_hi_reg, crf_lo_reg;
    logic                 out_valid_reg;
    logic [PW-1:0]        product_reg;
    logic [TAG_WIDTH-1:0] tag_reg;

    assign stall    = out_valid_reg && !out_ready;
    assign in_ready = !stall && !flush;

    // Extending straight to PW bits gives the same low PW product bits as a
    // (DWIDTH+1)-bit signed multiply, so the top product bits are never built.
    assign a_ext     = {{DWIDTH{~uns & a[DWIDTH-1]}}, a};
    assign b_ext     = {{DWIDTH{~uns & b[DWIDTH-1]}}, b};
    assign full_prod = a_ext * b_ext;

    always_comb begin
        in_stage         = '0;
        in_stage.valid   = in_valid && in_ready;
        in_stage.uns     = uns;
        in_stage.product = full_prod;
        in_stage.tag     = in_tag;
    end

    // Stages 0..STAGES-2 carry {valid, uns, product, tag}; the output register
    // is the final stage and holds the CR fields in place of uns.
    generate
        for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_stage
            stage_t feed;
            stage_t stage_reg;
            if (gi == 0) begin : g_from_input
                assign feed = in_stage;
            end else begin : g_from_prev
                assign feed = g_stage[gi-1].stage_reg;
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage_reg <= '0;
                end else if (flush) begin
                    stage_reg.valid <= 1'b0;
                end else if (!stall) begin
                    stage_reg <= feed;
                end
            end
        end
        if (STAGES == 1) begin : g_feed_input
            assign last_feed = in_stage;
        end else begin : g_feed_pipe
            assign last_feed = g_stage[STAGES-2].stage_reg;
        end
    endgenerate

    mul_crf_gen #(
        .DWIDTH (DWIDTH)
    ) u_crf (
        .res_hi (last_feed.product[PW-1:DWIDTH]),
        .res_lo (last_feed.product[DWIDTH-1:0]),
        .uns    (last_feed.uns),
        .crf_hi (crf_hi_next),
        .crf_lo (crf_lo_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            product_reg   <= '0;
            tag_reg       <= '0;
            crf_hi_reg    <= '0;
            crf_lo_reg    <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (!stall) begin
            out_valid_reg <= last_feed.valid;
            product_reg   <= last_feed.product;
            tag_reg       <= last_feed.tag;
            crf_hi_reg    <= crf_hi_next;
            crf_lo_reg    <= crf_lo_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign res_hi    = product_reg[PW-1:DWIDTH];
    assign res_lo    = product_reg[DWIDTH-1:0];
    assign out_tag   = tag_reg;
    assign crf_hi    = crf_hi_reg;
    assign crf_lo    = crf_lo_reg;

endmodule

// File: tb/tb_mul_pipe_gen.sv
// Self-checking bench for mul_pipe_gen: directed vectors, backpressure stream,
// flush, asynchronous reset and a randomized stream against a reference model.
module tb_mul_pipe_gen;
    import Pu_types::*;

    localparam int DW = 32;
    localparam int TW = 5;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          uns = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] res_hi, res_lo;
    Cr_field       crf_hi, crf_lo;
    logic [TW-1:0] out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_pipe_gen #(.DWIDTH(DW), .STAGES(ST), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .uns(uns), .a(a), .b(b),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .res_hi(res_hi), .res_lo(res_lo), .crf_hi(crf_hi), .crf_lo(crf_lo),
        .out_tag(out_tag)
    );

    typedef struct {
        logic          u;
        logic [DW-1:0] x, y;
        logic [TW-1:0] t;
    } op_t;

    typedef struct {
        logic [DW-1:0] hi, lo;
        logic [TW-1:0] tag;
        logic [3:0]    ch, cl;
    } exp_t;

    op_t  src_q[$];
    exp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // {lt,gt,eq,ov} of a word read as two's complement
    function automatic logic [3:0] ref_cr(input logic [DW-1:0] w);
        if ($signed(w) < 0) return 4'b1000;
        if (w == 0)         return 4'b0010;
        return 4'b0100;
    endfunction

    function automatic exp_t model(input op_t op);
        exp_t        e;
        longint      sx, sy;
        logic [63:0] p;
        if (op.u) begin
            p = {32'b0, op.x} * {32'b0, op.y};
        end else begin
            sx = $signed(op.x);
            sy = $signed(op.y);
            p  = sx * sy;
        end
        e.hi  = p[63:32];
        e.lo  = p[31:0];
        e.tag = op.t;
        e.ch  = ref_cr(e.hi);
        e.cl  = ref_cr(e.lo);
        if (op.u) e.cl[0] = (e.hi != 0);
        else      e.cl[0] = ($signed(p) != longint'($signed(e.lo)));
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'(($urandom_range(0, 200)));
            default: return $urandom;
        endcase
    endfunction

    // One op with out_ready high; checks latency and all result fields.
    task automatic single(input op_t op, input exp_t e);
        int n;
        uns = op.u; a = op.x; b = op.y; in_tag = op.t;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check_eq("single_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            n++;
        end
        check_eq("single_latency", n, ST);
        check_eq("single_hi", res_hi, e.hi);
        check_eq("single_lo", res_lo, e.lo);
        check_eq("single_tag", out_tag, e.tag);
        check_eq("single_crf_hi", crf_hi, e.ch);
        check_eq("single_crf_lo", crf_lo, e.cl);
        $display("[TB] single uns=%0d a=%h b=%h -> hi=%h lo=%h crf_hi=%b crf_lo=%b lat=%0d",
                 op.u, op.x, op.y, res_hi, res_lo, crf_hi, crf_lo, n);
        @(posedge clk); #1;
    endtask

    // mode 0: in_valid held, out_ready low for 4 cycles after first result.
    // mode 1: random in_valid / out_ready.
    task automatic run_stream(input int mode, input int n_ops, input int max_cycles);
        int            cyc = 0, hold_cnt = 0, got = 0;
        bit            first_done = 0, was_stalled = 0;
        logic [DW-1:0] sh = '0, sl = '0;
        logic [TW-1:0] st = '0;
        logic [3:0]    sch = '0, scl = '0;
        exp_t          e;
        while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < max_cycles) begin
            if (src_q.size() != 0 && (mode == 0 || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                uns = src_q[0].u; a = src_q[0].x; b = src_q[0].y; in_tag = src_q[0].t;
            end else begin
                in_valid = 1'b0;
            end
            if (mode == 0) out_ready = (hold_cnt == 0);
            else           out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check_eq("in_ready", in_ready, !(out_valid && !out_ready));
            if (was_stalled) begin
                check_eq("hold_valid", out_valid, 1'b1);
                check_eq("hold_data", {res_hi, res_lo}, {sh, sl});
                check_eq("hold_side", {out_tag, crf_hi, crf_lo}, {st, sch, scl});
            end
            was_stalled = 0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_result", out_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("stream_hi", res_hi, e.hi);
                        check_eq("stream_lo", res_lo, e.lo);
                        check_eq("stream_tag", out_tag, e.tag);
                        check_eq("stream_crf_hi", crf_hi, e.ch);
                        check_eq("stream_crf_lo", crf_lo, e.cl);
                        $display("[TB] stream out tag=%0d hi=%h lo=%h crf_hi=%b crf_lo=%b",
                                 out_tag, res_hi, res_lo, crf_hi, crf_lo);
                        got++;
                    end
                    if (mode == 0 && !first_done) begin
                        first_done = 1;
                        hold_cnt = 4;
                    end
                end else begin
                    was_stalled = 1;
                    sh = res_hi; sl = res_lo; st = out_tag; sch = crf_hi; scl = crf_lo;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(src_q.pop_front()));
            if (!out_ready && hold_cnt > 0) hold_cnt--;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("stream_timeout", cyc < max_cycles, 1'b1);
        check_eq("stream_count", got, n_ops);
    endtask

    initial begin
        op_t           op;
        exp_t          e;
        int            n, seen;
        logic [DW-1:0] vx[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [DW-1:0] vy[4]  = '{32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic          vu[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] vhi[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000, 32'h4000_0000};
        logic [DW-1:0] vlo[4] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
        logic [3:0]    vch[4] = '{4'b1000, 4'b1000, 4'b0010, 4'b0100};
        logic [3:0]    vcl[4] = '{4'b1000, 4'b0101, 4'b0100, 4'b0011};

        // reset state
        #12;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_res", {res_hi, res_lo}, 64'h0);
        check_eq("rst_side", {out_tag, crf_hi, crf_lo}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // directed vectors with literal expectations
        for (int i = 0; i < 4; i++) begin
            op = '{u: vu[i], x: vx[i], y: vy[i], t: 5'(i + 10)};
            e  = '{hi: vhi[i], lo: vlo[i], tag: 5'(i + 10), ch: vch[i], cl: vcl[i]};
            single(op, e);
        end
        // a few random singles against the model
        for (int i = 0; i < 4; i++) begin
            op = '{u: 1'($urandom_range(0, 1)), x: rand_word(), y: rand_word(), t: 5'($urandom_range(0, 31))};
            single(op, model(op));
        end

        // 6-op stream with a 4-cycle stall after the first result
        for (int i = 0; i < 6; i++)
            src_q.push_back('{u: 1'(i % 2), x: $urandom, y: $urandom, t: 5'(i)});
        run_stream(0, 6, 200);

        // flush while tags 1,2 in flight; tag 3 offered in the flush cycle
        out_ready = 1'b1; in_valid = 1'b1; uns = 1'b0; a = 32'd7; b = 32'd9; in_tag = 5'd1;
        @(posedge clk); #1;
        in_tag = 5'd2; a = 32'd5;
        @(posedge clk); #1;
        flush = 1'b1; in_tag = 5'd3; a = 32'd3;
        @(negedge clk);
        check_eq("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; in_tag = 5'd4; a = 32'd11; b = 32'd13;
        @(negedge clk);
        check_eq("flush_clears_valid", out_valid, 1'b0);
        check_eq("post_flush_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            n++;
        end
        check_eq("flush_next_latency", n, ST);
        check_eq("flush_next_tag", out_tag, 5'd4);
        check_eq("flush_next_lo", res_lo, 32'd143);
        $display("[TB] flush: first result tag=%0d lo=%0d lat=%0d", out_tag, res_lo, n);
        @(posedge clk); #1;

        // randomized stream with random backpressure
        for (int i = 0; i < 40; i++)
            src_q.push_back('{u: 1'($urandom_range(0, 1)), x: rand_word(), y: rand_word(), t: 5'(i)});
        run_stream(1, 40, 1000);

        // asynchronous reset with two ops in flight and a stalled result
        out_ready = 1'b0; in_valid = 1'b1; uns = 1'b1; a = 32'd6; b = 32'd7; in_tag = 5'd7;
        @(posedge clk); #1;
        in_tag = 5'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            n++;
        end
        check_eq("pre_reset_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_valid", out_valid, 1'b0);
        check_eq("async_rst_res", {res_hi, res_lo}, 64'h0);
        check_eq("async_rst_side", {out_tag, crf_hi, crf_lo}, 0);
        $display("[TB] async reset: out_valid=%0d res=%h_%h", out_valid, res_hi, res_lo);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check_eq("release_in_ready", in_ready, 1'b1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("stale_after_reset", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
